spi_pi_master: RTL and testbench

//  SPI master (initiator) for the Pi-link SPI slave port (spi_clk/spi_cs/spi_mosi/spi_miso) on the Nios SOPC.

---
 rtl/spi_pi_pkg.sv | 19 +
 rtl/spi_pi_master_if.sv | 29 ++
 rtl/spi_pi_sclk_gen.sv | 42 ++++
 rtl/spi_pi_master.sv | 174 +++++++++++++++++
 tb/tb_spi_pi_master.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pi_pkg.sv
// Shared types and constants for the Pi-link SPI master.
// Frame layout: bit 39 = write flag, bits 38:32 = address, bits 31:0 = data.
package spi_pi_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int WR_BIT  = FRAME_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_pi_master_if.sv
// Command/response handshake and SPI pins of the Pi-link SPI master.
// The master modport is the controller's view; slave is the user/pin side.
interface spi_pi_master_if;
    import spi_pi_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              spi_clk;
    logic              spi_cs;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, spi_miso,
        output cmd_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, spi_miso,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_clk, spi_cs, spi_mosi
    );

endinterface

// File: rtl/spi_pi_sclk_gen.sv
// SPI clock divider: registered spi_clk plus rise/fall strobes.
// A strobe is high in the cycle before spi_clk changes, so logic acting on
// the strobe lines up with the visible edge. Counter runs CLK_DIV-1 down to 0.
module spi_pi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic rise_tick,
    output logic fall_tick,
    output logic spi_clk
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;
    logic             sclk_q;

    assign rise_tick = en && (div_cnt == '0) && !sclk_q;
    assign fall_tick = en && (div_cnt == '0) &&  sclk_q;
    assign spi_clk   = sclk_q;

    // Half-period down-counter; toggles spi_clk at terminal count.
    always_ff @(posedge clk_clk) begin
        if (reset || clr) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (en) begin
            if (div_cnt == '0) begin
                div_cnt <= DIV_LOAD;
                sclk_q  <= ~sclk_q;
            end else begin
                div_cnt <= div_cnt - DIV_ONE;
            end
        end
    end

endmodule

// File: rtl/spi_pi_master.sv
// Pi-link SPI master: single-word read/write commands to 40-bit mode-0 frames.
// Optional build macro: SPI_MISO_SYNC_EN adds a 2-flop MISO synchronizer,
// moves the capture point 2 cycles after each rising spi_clk and stretches
// HOLD by 2 cycles.
//
//  state | meaning
//  IDLE  | ready; divider cleared; command latched on accept
//  SETUP | cs low, first bit on MOSI, waiting for the first rising spi_clk
//  SHIFT | spi_clk running; MISO sampled on rise, MOSI advanced on fall
//  HOLD  | clock stopped, cs still low, MOSI back to 0
//  GAP   | cs high, response published, enforced idle before next command
module spi_pi_master
    import spi_pi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic           clk_clk,
    input  logic           reset,
    spi_pi_master_if.master bus
);

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    state_t               state, state_nxt;
    logic [TMR_W-1:0]     tmr;
    logic [5:0]           bit_cnt;
    logic [FRAME_W-1:0]   tx_sh;
    logic [DATA_W-1:0]    rx_sh;
    logic                 rise_tick, fall_tick, last_fall;
    logic                 sample_tick, sample_bit;
    logic                 sclk_en, sclk_clr, sclk;
    logic                 ready_c, cs_c, mosi_c;
    logic                 rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

`ifdef SPI_MISO_SYNC_EN
    localparam int HOLD_LEN = CLK_DIV + 2;
    logic [1:0] miso_sync, rise_dly;

    // MISO synchronizer and matching delay of the rise strobe.
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            miso_sync <= '0;
            rise_dly  <= '0;
        end else begin
            miso_sync <= {miso_sync[0], bus.spi_miso};
            rise_dly  <= {rise_dly[0], rise_tick};
        end
    end

    assign sample_bit  = miso_sync[1];
    assign sample_tick = rise_dly[1];
`else
    localparam int HOLD_LEN = CLK_DIV;
    assign sample_bit  = bus.spi_miso;
    assign sample_tick = rise_tick;
`endif

    spi_pi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk_clk   (clk_clk),
        .reset     (reset),
        .en        (sclk_en),
        .clr       (sclk_clr),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .spi_clk   (sclk)
    );

    assign last_fall = fall_tick && (bit_cnt == 6'd1);

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and pin decode. SHIFT is entered one cycle before the first
    // visible rising spi_clk because the divider output is registered.
    always_comb begin
        state_nxt = state;
        sclk_en   = 1'b0;
        sclk_clr  = 1'b0;
        ready_c   = 1'b0;
        cs_c      = 1'b1;
        mosi_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c  = 1'b1;
                sclk_clr = 1'b1;
                if (bus.cmd_valid) state_nxt = SETUP;
            end
            SETUP: begin
                cs_c   = 1'b0;
                mosi_c = tx_sh[WR_BIT];
                if (tmr == '0) state_nxt = SHIFT;
            end
            SHIFT: begin
                cs_c    = 1'b0;
                mosi_c  = tx_sh[WR_BIT];
                sclk_en = 1'b1;
                if (last_fall) state_nxt = HOLD;
            end
            HOLD: begin
                cs_c = 1'b0;
                if (tmr == '0) state_nxt = GAP;
            end
            GAP: begin
                if (tmr == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: shift registers, bit counter, phase timer, response.
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            tmr         <= '0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        tx_sh   <= {bus.cmd_write, bus.cmd_addr,
                                    bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}}};
                        bit_cnt <= 6'(FRAME_W);
                        tmr     <= TMR_W'(CLK_DIV - 2);
                    end
                end
                SETUP: begin
                    if (tmr != '0) tmr <= tmr - TMR_ONE;
                end
                SHIFT: begin
                    if (fall_tick) begin
                        if (bit_cnt != 6'd0) bit_cnt <= bit_cnt - 6'd1;
                        if (!last_fall) tx_sh <= {tx_sh[FRAME_W-2:0], 1'b0};
                    end
                    if (last_fall) tmr <= TMR_W'(HOLD_LEN - 1);
                end
                HOLD: begin
                    if (tmr == '0) begin
                        tmr         <= TMR_W'(CS_GAP - 1);
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rx_sh;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                GAP: begin
                    if (tmr != '0) tmr <= tmr - TMR_ONE;
                end
                default: tmr <= '0;
            endcase
            // Only data-phase bits (counter 32..1) are kept; command phase is dropped.
            if (sample_tick && (bit_cnt <= 6'(DATA_W)) && (bit_cnt != 6'd0))
                rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
        end
    end

    assign bus.cmd_ready = ready_c;
    assign bus.busy      = ~ready_c;
    assign bus.spi_cs    = cs_c;
    assign bus.spi_mosi  = mosi_c;
    assign bus.spi_clk   = sclk;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_pi_master.sv
// Directed bench for spi_pi_master (CLK_DIV=4, CS_GAP=2).
// Honours SPI_MISO_SYNC_EN for the expected response timing.
module tb_spi_pi_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;
    localparam int MAX_CYC = 450;
`ifdef SPI_MISO_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int EXP_CS_LAST = 80 * CLK_DIV + CLK_DIV + EXTRA;      // 324
    localparam int EXP_RV      = 1 + 81 * CLK_DIV + EXTRA;            // 325
    localparam int EXP_RDY     = 1 + 81 * CLK_DIV + CS_GAP + EXTRA;   // 327

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    spi_pi_master_if bus ();

    spi_pi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Mode-0 slave model: presents word bit (39-idx), advances on spi_clk fall.
    logic [39:0] slave_word = '0;
    bit          slv_delay  = 1'b0;
    int          slv_idx    = 0;
    logic        sclk_prev_s = 1'b0;
    logic        miso_raw, miso_d = 1'b0;

    always @(posedge clk) begin
        sclk_prev_s <= bus.spi_clk;
        miso_d      <= miso_raw;
        if (bus.spi_cs) slv_idx <= 0;
        else if (sclk_prev_s && !bus.spi_clk) slv_idx <= slv_idx + 1;
    end

    assign miso_raw     = (!bus.spi_cs && slv_idx < 40) ? slave_word[39 - slv_idx] : 1'b0;
    assign bus.spi_miso = slv_delay ? miso_d : miso_raw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready, presents a command and lets it be accepted.
    task automatic issue(input logic wr, input logic [6:0] addr, input logic [31:0] wdata,
                         input bit hold_valid);
        bit got = 0;
        for (int i = 0; i < MAX_CYC && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) got = 1;
        end
        check("ready_wait", 64'(got), 64'd1);
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) bus.cmd_valid = 1'b0;
    endtask

    // Follows one frame from cycle 1 until cmd_ready returns.
    task automatic observe(input bit pulse_valid,
                           output int cs_first, output int cs_last, output int rv_cyc,
                           output int rv_cnt, output int rdy_cyc, output int rise1,
                           output int nrise, output int cs_hi_busy,
                           output logic [39:0] mosi_bits, output logic [31:0] rdata);
        logic sclk_prev = 1'b0;
        bit   done = 0;
        cs_first = -1; cs_last = -1; rv_cyc = -1; rv_cnt = 0; rdy_cyc = -1;
        rise1 = -1; nrise = 0; cs_hi_busy = 0; mosi_bits = '0; rdata = '0;
        for (int c = 1; c <= MAX_CYC && !done; c++) begin
            @(negedge clk);
            if (pulse_valid) bus.cmd_valid = (c % 7 == 3);
            if (!bus.spi_cs) begin
                if (cs_first < 0) cs_first = c;
                cs_last = c;
            end else if (cs_last > 0 && bus.busy) begin
                cs_hi_busy++;
            end
            if (bus.spi_clk && !sclk_prev) begin
                nrise++;
                if (rise1 < 0) rise1 = c;
                mosi_bits = {mosi_bits[38:0], bus.spi_mosi};
            end
            sclk_prev = bus.spi_clk;
            if (bus.rsp_valid) begin
                rv_cnt++;
                if (rv_cyc < 0) rv_cyc = c;
                rdata = bus.rsp_rdata;
            end
            if (bus.cmd_ready) begin
                rdy_cyc = c;
                done = 1;
                if (pulse_valid) bus.cmd_valid = 1'b0;
            end
        end
        check("frame_done", 64'(done), 64'd1);
    endtask

    int          csf, csl, rvc, rvn, rdc, r1, nr, chb;
    logic [39:0] mb;
    logic [31:0] rd;
    int          rv_seen;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        // 1: reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs",        64'(bus.spi_cs),    64'd1);
        check("rst_sclk",      64'(bus.spi_clk),   64'd0);
        check("rst_ready",     64'(bus.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rdata",     64'(bus.rsp_rdata), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_mosi",      64'(bus.spi_mosi),  64'd0);
        reset = 1'b0;

        // 2: write 0x15 <= 0xDEADBEEF, stray cmd_valid pulses while busy
        slave_word = 40'h00_0000_0000;
        issue(1'b1, 7'h15, 32'hDEAD_BEEF, 1'b0);
        observe(1'b1, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("wr_mosi",     64'(mb),  64'h95_DEAD_BEEF);
        check("wr_nrise",    64'(nr),  64'd40);
        check("wr_rise1",    64'(r1),  64'(1 + CLK_DIV));
        check("wr_cs_first", 64'(csf), 64'd1);
        check("wr_cs_last",  64'(csl), 64'(EXP_CS_LAST));
        check("wr_rv_cyc",   64'(rvc), 64'(EXP_RV));
        check("wr_rv_cnt",   64'(rvn), 64'd1);
        check("wr_rdy_cyc",  64'(rdc), 64'(EXP_RDY));
        @(negedge clk);
        check("wr_no_reaccept", 64'(bus.cmd_ready), 64'd1);

        // 3: read 0x03, slave returns 0xA5A50F0F, write data must be ignored
        slave_word = {8'h5A, 32'hA5A5_0F0F};
        issue(1'b0, 7'h03, 32'hFFFF_FFFF, 1'b0);
        observe(1'b0, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("rd_mosi",   64'(mb),  64'h03_0000_0000);
        check("rd_rdata",  64'(rd),  64'hA5A5_0F0F);
        check("rd_rv_cyc", 64'(rvc), 64'(EXP_RV));
        check("rd_rdata_hold", 64'(bus.rsp_rdata), 64'hA5A5_0F0F);

        // 4: back-to-back, cmd_valid held high, inputs changed mid-frame
        slave_word = 40'hFF_FFFF_FFFF;
        issue(1'b1, 7'h01, 32'h0000_0001, 1'b1);
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'h2A;
        bus.cmd_wdata = 32'h5555_5555;
        observe(1'b0, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("b2b_mosi1",  64'(mb),  64'h81_0000_0001);
        check("b2b_rdy1",   64'(rdc), 64'(EXP_RDY));
        check("b2b_gap_cs", 64'(chb), 64'(CS_GAP));
        check("b2b_rdata1", 64'(rd),  64'hFFFF_FFFF);
        slave_word = {8'h00, 32'h3C3C_C3C3};
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        observe(1'b0, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("b2b_cs_first2", 64'(csf), 64'd1);
        check("b2b_mosi2",     64'(mb),  64'h2A_0000_0000);
        check("b2b_rdata2",    64'(rd),  64'h3C3C_C3C3);

        // 5: reset at cycle 100 of a read frame
        slave_word = {8'h00, 32'h1234_5678};
        issue(1'b0, 7'h11, 32'h0, 1'b0);
        rv_seen = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs",    64'(bus.spi_cs),    64'd1);
        check("abort_sclk",  64'(bus.spi_clk),   64'd0);
        check("abort_ready", 64'(bus.cmd_ready), 64'd1);
        check("abort_mosi",  64'(bus.spi_mosi),  64'd0);
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_seen++;
        end
        check("abort_no_rsp", 64'(rv_seen), 64'd0);
        issue(1'b1, 7'h7F, 32'h1234_5678, 1'b0);
        observe(1'b0, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("post_abort_mosi", 64'(mb),  64'hFF_1234_5678);
        check("post_abort_rv",   64'(rvc), 64'(EXP_RV));

        // 6: read with MISO delayed one clock by the slave
        slv_delay  = 1'b1;
        slave_word = {8'h00, 32'hA5A5_0F0F};
        issue(1'b0, 7'h03, 32'h0, 1'b0);
        observe(1'b0, csf, csl, rvc, rvn, rdc, r1, nr, chb, mb, rd);
        check("dly_rdata",  64'(rd),  64'hA5A5_0F0F);
        check("dly_rv_cyc", 64'(rvc), 64'(EXP_RV));
        check("dly_rdy",    64'(rdc), 64'(EXP_RDY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
